// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it out one bit per clock with valid and last-bit markers.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;

  // Ready is derived only from state registers, so there is no combinational
  // path from din/load_valid to any output.
  assign last_bit   = (state_q == SHIFT) && (cnt_q == CW'(WIDTH));
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shift_d = din;
          cnt_d   = CW'(1);
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (accept) begin
            shift_d = din;
            cnt_d   = CW'(1);
          end else begin
            // Clearing the shift register keeps sout at 0 while idle.
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
          end
        end else begin
          if (LSB_FIRST) shift_d = shift_q >> 1;
          else           shift_d = shift_q << 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sout       = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
  assign sout_valid = (state_q == SHIFT);
  assign sout_last  = last_bit;
  assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: the driver queues expected bits at each
// accept, a negedge monitor pops and compares whenever sout_valid is high.
module tb_piso_serializer;

  typedef struct packed {
    logic bit_v;
    logic last_v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din, din2;
  logic       load_valid, load_valid2;
  logic       load_ready, sout, sout_valid, sout_last, busy;
  logic       load_ready2, sout2, sout_valid2, sout_last2, busy2;
  logic [3:0] sipo_q, sipo2_q;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   run_len = 0;
  int   max_run = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid),
    .sout_last(sout_last), .busy(busy)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .din(din2), .load_valid(load_valid2),
    .load_ready(load_ready2), .sout(sout2), .sout_valid(sout_valid2),
    .sout_last(sout_last2), .busy(busy2)
  );

  // Receiver models: LSB-first shifts in at the MSB, MSB-first at the LSB.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sipo_q  <= '0;
      sipo2_q <= '0;
    end else begin
      if (sout_valid)  sipo_q  <= {sout, sipo_q[3:1]};
      if (sout_valid2) sipo2_q <= {sipo2_q[2:0], sout2};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back('{bit_v: w[i], last_v: (i == 3)});
  endtask

  always @(negedge clk) begin
    if (sout_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        check("spurious_valid", sout_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sout", sout, e.bit_v);
        check("sout_last", sout_last, e.last_v);
        check("load_ready_in_shift", load_ready, e.last_v);
        check("busy_in_shift", busy, 1);
      end
    end else begin
      run_len = 0;
      check("idle_outputs", {sout, sout_last, busy, load_ready}, 4'b0001);
    end
  end

  // Holds load_valid until accepted; returns the number of refused cycles.
  task automatic send_word(input logic [3:0] w, output int rejects);
    bit acc = 1'b0;
    din        = w;
    load_valid = 1'b1;
    rejects    = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (load_ready) begin
        acc = 1'b1;
        push_word(w);
      end else begin
        rejects++;
      end
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    din        = ~w;
    check("accept_timeout", acc, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || sout_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", (n < 50), 1);
  endtask

  initial begin
    int rej;
    rst = 1'b0; din = '0; load_valid = 1'b0; din2 = '0; load_valid2 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {sout, sout_valid, sout_last, busy, load_ready}, 5'b00001);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word, then back to idle
    send_word(4'b1011, rej);
    check("single_rejects", rej, 0);
    wait_idle();
    check("single_idle", {sout_valid, load_ready}, 2'b01);

    // Back-to-back words with no gap
    max_run = 0;
    send_word(4'b1011, rej);
    send_word(4'b0110, rej);
    check("b2b_rejects", rej, 3);
    wait_idle();
    check("b2b_run_len", max_run, 8);

    // load_valid ignored during bits 1-3
    send_word(4'h0, rej);
    send_word(4'hF, rej);
    check("ignore_rejects", rej, 3);
    wait_idle();

    // Async reset between edges during bit 2
    send_word(4'b1110, rej);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outputs", {sout, sout_valid, sout_last, busy, load_ready}, 5'b00001);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_word(4'b0101, rej);
    check("post_rst_rejects", rej, 0);
    wait_idle();

    // Loopback into receiver model, LSB-first
    send_word(4'b1001, rej);
    repeat (4) @(posedge clk);
    #1;
    check("sipo_lsb_q", sipo_q, 4'b1001);
    wait_idle();

    // MSB-first instance: 1,0,0,1 on the wire
    din2 = 4'b1001;
    load_valid2 = 1'b1;
    @(posedge clk);
    #1;
    load_valid2 = 1'b0;
    din2 = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      check("msb_sout", sout2, din2[3-i] ^ 1'b1);
      check("msb_valid", sout_valid2, 1);
      check("msb_last", sout_last2, (i == 3));
      @(posedge clk);
      #1;
    end
    check("msb_idle", {sout2, sout_valid2, load_ready2}, 3'b001);
    check("sipo_msb_q", sipo2_q, 4'b1001);

    @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
